// File: rtl/pulse_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pulse_pkg
//  Description : Shared types and helpers for the pulse stretcher: state
//                encoding, default counter width and the zero-width clamp.
//  Revision    : 1.0  initial release
// ============================================================================
package pulse_pkg;

  // Default width of the delay/width counters and their programming inputs.
  localparam int DEFAULT_CNT_W = 16;

  // Controller states; encodings are fixed so status can be decoded externally.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DELAY  = 2'd1,
    ST_ACTIVE = 2'd2
  } state_e;

  // A programmed width of zero still produces a one-cycle pulse.
  function automatic logic [63:0] at_least_one(input logic [63:0] w);
    return (w == 64'd0) ? 64'd1 : w;
  endfunction

endpackage : pulse_pkg
`default_nettype wire

// File: rtl/pulse_down_counter.sv
`default_nettype none
// ============================================================================
//  Module      : pulse_down_counter
//  Description : Loadable CNT_W-bit down-counter. Load has priority over
//                decrement; the count saturates at zero so it never wraps.
//                o_terminal flags a count of exactly one, i.e. the last cycle
//                of the interval being timed.
//  Revision    : 1.0  initial release
// ============================================================================
module pulse_down_counter
  import pulse_pkg::*;
#(
  parameter int CNT_W = DEFAULT_CNT_W
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  input  logic             i_dec,
  output logic             o_terminal
);

  localparam logic [CNT_W-1:0] C_ONE = CNT_W'(1);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // Next count: a load wins, otherwise step down without passing zero.
  always_comb begin
    count_d = count_q;
    if (i_load) begin
      count_d = i_load_val;
    end else if (i_dec && (count_q != '0)) begin
      count_d = count_q - C_ONE;
    end
  end

  // Count register with synchronous clear.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign o_terminal = (count_q == C_ONE);

endmodule : pulse_down_counter
`default_nettype wire

// File: rtl/pulse_stretcher.sv
`default_nettype none
// ============================================================================
//  Module      : pulse_stretcher
//  Description : Turns a single-cycle trigger into a registered level pulse of
//                programmable width, optionally after a programmable delay.
//                Reports busy and flags triggers ignored while busy.
//                Optional build macro RETRIGGER_EN: a trigger while the pulse
//                is high restarts the width count instead of being dropped.
//  Revision    : 1.0  initial release
// ============================================================================
module pulse_stretcher
  import pulse_pkg::*;
#(
  parameter int CNT_W = DEFAULT_CNT_W
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_enable,
  input  logic             i_trig,
  input  logic [CNT_W-1:0] i_delay,
  input  logic [CNT_W-1:0] i_width,
  output logic             o_pulse,
  output logic             o_busy,
  output logic             o_dropped
);

  state_e state_q;
  state_e state_d;
  logic   pulse_q;
  logic   pulse_d;
  logic   busy_q;
  logic   busy_d;
  logic   dropped_q;
  logic   dropped_d;

  logic             w_accept;
  logic             w_reload;
  logic             w_delay_term;
  logic             w_width_term;
  logic             w_width_load;
  logic             w_delay_dec;
  logic             w_width_dec;
  logic [CNT_W-1:0] w_width_eff;

  // Width actually loaded: zero is promoted to one.
  assign w_width_eff = CNT_W'(at_least_one(64'(i_width)));

  // The width counter is loaded on acceptance and (optionally) on retrigger;
  // it only counts while the pulse is high, so it holds through DELAY.
  assign w_width_load = w_accept | w_reload;
  assign w_delay_dec  = (state_q == ST_DELAY);
  assign w_width_dec  = (state_q == ST_ACTIVE) && !w_reload;

  pulse_down_counter #(
    .CNT_W (CNT_W)
  ) u_delay_cnt (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_load     (w_accept),
    .i_load_val (i_delay),
    .i_dec      (w_delay_dec),
    .o_terminal (w_delay_term)
  );

  pulse_down_counter #(
    .CNT_W (CNT_W)
  ) u_width_cnt (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_load     (w_width_load),
    .i_load_val (w_width_eff),
    .i_dec      (w_width_dec),
    .o_terminal (w_width_term)
  );

  // Next-state logic; the registered outputs are decoded from the next state
  // so they change on the same edge as the state register.
  always_comb begin
    state_d   = state_q;
    w_accept  = 1'b0;
    w_reload  = 1'b0;
    dropped_d = 1'b0;

    if (!i_enable) begin
      // Disabled: abort whatever is in flight; triggers vanish silently.
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (i_trig) begin
            w_accept = 1'b1;
            state_d  = (i_delay == '0) ? ST_ACTIVE : ST_DELAY;
          end
        end

        ST_DELAY: begin
          if (i_trig) begin
            dropped_d = 1'b1;
          end
          if (w_delay_term) begin
            state_d = ST_ACTIVE;
          end
        end

        ST_ACTIVE: begin
`ifdef RETRIGGER_EN
          if (i_trig) begin
            // Restart the width count; the pulse stays high without a gap.
            w_reload = 1'b1;
          end else if (w_width_term) begin
            state_d = ST_IDLE;
          end
`else
          if (i_trig) begin
            dropped_d = 1'b1;
          end
          if (w_width_term) begin
            state_d = ST_IDLE;
          end
`endif
        end

        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end

    pulse_d = (state_d == ST_ACTIVE);
    busy_d  = (state_d != ST_IDLE);
  end

  // State and status registers; reset ends any pulse immediately.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q   <= ST_IDLE;
      pulse_q   <= 1'b0;
      busy_q    <= 1'b0;
      dropped_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pulse_q   <= pulse_d;
      busy_q    <= busy_d;
      dropped_q <= dropped_d;
    end
  end

  assign o_pulse   = pulse_q;
  assign o_busy    = busy_q;
  assign o_dropped = dropped_q;

endmodule : pulse_stretcher
`default_nettype wire

// File: tb/tb_pulse_stretcher.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pulse_stretcher
//  Description : Self-checking bench for pulse_stretcher. Directed vector
//                table, a maximum-delay sequence and a randomized run checked
//                against an interval-based reference model.
//                Honours RETRIGGER_EN the same way as the design.
//                Outputs are examined 1 ns after each rising edge, so the
//                value checked for edge k is what the registers took at k.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_pulse_stretcher;

  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             i_reset;
  logic             i_enable;
  logic             i_trig;
  logic [CNT_W-1:0] i_delay;
  logic [CNT_W-1:0] i_width;
  logic             o_pulse;
  logic             o_busy;
  logic             o_dropped;

  int     errors = 0;
  int     checks = 0;
  longint edge_k = 0;

  always #5 clk = ~clk;

  pulse_stretcher #(
    .CNT_W (CNT_W)
  ) dut (
    .i_clk     (clk),
    .i_reset   (i_reset),
    .i_enable  (i_enable),
    .i_trig    (i_trig),
    .i_delay   (i_delay),
    .i_width   (i_width),
    .o_pulse   (o_pulse),
    .o_busy    (o_busy),
    .o_dropped (o_dropped)
  );

  // ---------------- reference model: one pulse as an interval of edges ------
  // A pulse accepted at edge a keeps busy high after edges a..e and the
  // output high after edges s..e, where s = a + D and e = s + W - 1.
  bit     m_valid = 1'b0;
  longint m_acc   = 0;
  longint m_start = 0;
  longint m_end   = 0;
  bit     m_drop  = 1'b0;

  function automatic bit m_busy(input longint k);
    return m_valid && (k >= m_acc) && (k <= m_end);
  endfunction

  function automatic bit m_active(input longint k);
    return m_valid && (k >= m_start) && (k <= m_end);
  endfunction

  task automatic model_edge(input logic rst, input logic en, input logic trig,
                            input logic [CNT_W-1:0] d, input logic [CNT_W-1:0] w);
    bit     was_busy;
    bit     was_active;
    longint wm;
    was_busy   = m_busy(edge_k - 1);
    was_active = m_active(edge_k - 1);
    wm         = (w == '0) ? 64'd1 : longint'(w);
    m_drop     = 1'b0;
    if (rst || !en) begin
      m_valid = 1'b0;
    end else if (trig) begin
      if (!was_busy) begin
        m_valid = 1'b1;
        m_acc   = edge_k;
        m_start = edge_k + longint'(d);
        m_end   = edge_k + longint'(d) + wm - 1;
      end else begin
`ifdef RETRIGGER_EN
        if (was_active) m_end = edge_k + wm - 1;
        else            m_drop = 1'b1;
`else
        m_drop = 1'b1;
`endif
      end
    end
  endtask

  // ---------------- helpers -------------------------------------------------
  task automatic drive_edge(input logic rst, input logic en, input logic trig,
                            input logic [CNT_W-1:0] d, input logic [CNT_W-1:0] w);
    i_reset  = rst;
    i_enable = en;
    i_trig   = trig;
    i_delay  = d;
    i_width  = w;
    @(posedge clk);
    edge_k++;
    model_edge(rst, en, trig, d, w);
    #1;
  endtask

  task automatic check(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @edge %0d: got %b, want %b", name, edge_k, act, exp);
    end
  endtask

  task automatic check_model(input string tag);
    check({tag, ".pulse"},   o_pulse,   m_active(edge_k));
    check({tag, ".busy"},    o_busy,    m_busy(edge_k));
    check({tag, ".dropped"}, o_dropped, m_drop);
  endtask

  // ---------------- directed vector table -----------------------------------
  typedef struct {
    logic             rst;
    logic             en;
    logic             trig;
    logic [CNT_W-1:0] d;
    logic [CNT_W-1:0] w;
    int               n;      // consecutive edges with these inputs
    logic             p;      // expected o_pulse after each of those edges
    logic             b;      // expected o_busy
    logic             dr;     // expected o_dropped
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic rst, input logic en, input logic trig,
                              input int d, input int w, input int n,
                              input logic p, input logic b, input logic dr);
    vec_t v;
    v.rst = rst; v.en = en; v.trig = trig;
    v.d = CNT_W'(d); v.w = CNT_W'(w); v.n = n;
    v.p = p; v.b = b; v.dr = dr;
    return v;
  endfunction

  initial begin
    i_reset  = 1'b1;
    i_enable = 1'b0;
    i_trig   = 1'b0;
    i_delay  = '0;
    i_width  = '0;

    // reset, then D=0 W=1: one cycle high, no drop
    vecs.push_back(mk(1, 1, 0, 0, 0, 2, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 0, 3, 0, 0, 0));
    vecs.push_back(mk(0, 1, 1, 0, 1, 1, 1, 1, 0));
    vecs.push_back(mk(0, 1, 0, 0, 0, 3, 0, 0, 0));
    // D=3 W=5, with i_delay/i_width changed after acceptance
    vecs.push_back(mk(0, 1, 1, 3, 5, 1, 0, 1, 0));
    vecs.push_back(mk(0, 1, 0, 9, 9, 2, 0, 1, 0));
    vecs.push_back(mk(0, 1, 0, 9, 9, 5, 1, 1, 0));
    vecs.push_back(mk(0, 1, 0, 9, 9, 2, 0, 0, 0));
    // W=0 behaves as W=1
    vecs.push_back(mk(0, 1, 1, 0, 0, 1, 1, 1, 0));
    vecs.push_back(mk(0, 1, 0, 0, 0, 2, 0, 0, 0));
    // D=0 W=4, second trigger three edges later
    vecs.push_back(mk(0, 1, 1, 0, 4, 1, 1, 1, 0));
    vecs.push_back(mk(0, 1, 0, 0, 4, 2, 1, 1, 0));
`ifdef RETRIGGER_EN
    vecs.push_back(mk(0, 1, 1, 0, 4, 1, 1, 1, 0));
    vecs.push_back(mk(0, 1, 0, 0, 4, 3, 1, 1, 0));
    vecs.push_back(mk(0, 1, 0, 0, 4, 1, 0, 0, 0));
    // D=0 W=2, trigger every edge: pulse held, nothing dropped
    vecs.push_back(mk(0, 1, 1, 0, 2, 4, 1, 1, 0));
    vecs.push_back(mk(0, 1, 0, 0, 2, 1, 1, 1, 0));
    vecs.push_back(mk(0, 1, 0, 0, 2, 2, 0, 0, 0));
`else
    vecs.push_back(mk(0, 1, 1, 0, 4, 1, 1, 1, 1));
    vecs.push_back(mk(0, 1, 0, 0, 4, 2, 0, 0, 0));
    // D=0 W=2: trigger on the final high cycle dropped, next one accepted
    vecs.push_back(mk(0, 1, 1, 0, 2, 1, 1, 1, 0));
    vecs.push_back(mk(0, 1, 1, 0, 2, 1, 1, 1, 1));
    vecs.push_back(mk(0, 1, 1, 0, 2, 1, 0, 0, 1));
    vecs.push_back(mk(0, 1, 1, 0, 2, 1, 1, 1, 0));
    vecs.push_back(mk(0, 1, 0, 0, 2, 1, 1, 1, 0));
    vecs.push_back(mk(0, 1, 0, 0, 2, 2, 0, 0, 0));
`endif
    // trigger during DELAY is dropped in every build
    vecs.push_back(mk(0, 1, 1, 2, 1, 1, 0, 1, 0));
    vecs.push_back(mk(0, 1, 1, 2, 1, 1, 0, 1, 1));
    vecs.push_back(mk(0, 1, 0, 2, 1, 1, 1, 1, 0));
    vecs.push_back(mk(0, 1, 0, 2, 1, 2, 0, 0, 0));
    // D=2 W=10, reset mid-pulse (with a trigger present), then a clean trigger
    vecs.push_back(mk(0, 1, 1, 2, 10, 1, 0, 1, 0));
    vecs.push_back(mk(0, 1, 0, 2, 10, 1, 0, 1, 0));
    vecs.push_back(mk(0, 1, 0, 2, 10, 3, 1, 1, 0));
    vecs.push_back(mk(1, 1, 1, 2, 10, 1, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 2, 10, 1, 0, 0, 0));
    vecs.push_back(mk(0, 1, 1, 0, 1, 1, 1, 1, 0));
    vecs.push_back(mk(0, 1, 0, 0, 1, 2, 0, 0, 0));
    // D=0 W=8, enable dropped mid-pulse; triggers while disabled vanish
    vecs.push_back(mk(0, 1, 1, 0, 8, 1, 1, 1, 0));
    vecs.push_back(mk(0, 1, 0, 0, 8, 1, 1, 1, 0));
    vecs.push_back(mk(0, 0, 1, 0, 8, 1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 8, 1, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 8, 2, 0, 0, 0));

    foreach (vecs[i]) begin
      for (int j = 0; j < vecs[i].n; j++) begin
        drive_edge(vecs[i].rst, vecs[i].en, vecs[i].trig, vecs[i].d, vecs[i].w);
        check($sformatf("vec%0d.pulse", i),   o_pulse,   vecs[i].p);
        check($sformatf("vec%0d.busy", i),    o_busy,    vecs[i].b);
        check($sformatf("vec%0d.dropped", i), o_dropped, vecs[i].dr);
      end
    end

    // ---------------- maximum delay must not wrap: D=2^16-1, W=0 ------------
    drive_edge(0, 1, 1, 16'hFFFF, 16'h0000);
    check("maxd.accept_busy", o_busy, 1'b1);
    for (int j = 1; j < 65535; j++) begin
      drive_edge(0, 1, 0, 16'h0000, 16'h0000);
      check_model("maxd");
    end
    drive_edge(0, 1, 0, 16'h0000, 16'h0000);
    check("maxd.pulse_on", o_pulse, 1'b1);
    drive_edge(0, 1, 0, 16'h0000, 16'h0000);
    check("maxd.pulse_off", o_pulse, 1'b0);
    check("maxd.busy_off",  o_busy,  1'b0);

    // ---------------- randomized run against the model ----------------------
    drive_edge(1, 1, 0, 16'h0000, 16'h0000);
    check_model("rnd_reset");
    for (int j = 0; j < 3000; j++) begin
      drive_edge(($urandom_range(0, 59) == 0),
                 ($urandom_range(0, 19) != 0),
                 ($urandom_range(0, 2) == 0),
                 CNT_W'($urandom_range(0, 5)),
                 CNT_W'($urandom_range(0, 5)));
      check_model("rnd");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_pulse_stretcher
`default_nettype wire

// File: doc/pulse_stretcher.md
Name: pulse_stretcher

Overview:
- Converts a single-cycle trigger pulse into a level pulse of programmable width, optionally after a programmable delay.
- Reverse of the channel unit's level-to-oneshot edge conversion.
- Sits in the channel unit between trigger/oneshot logic and the timing output pins, or downstream logic that needs a multi-cycle strobe.
- Reports busy status and flags triggers that arrive while a pulse is in progress.

Parameters:
- CNT_W, 16, width of the delay and width counters and their programming inputs.

Ports:
- i_clk  in  1  system clock; all logic on rising edge.
- i_reset  in  1  synchronous, active-high reset.
- i_enable  in  1  block enable; low aborts activity and ignores triggers.
- i_trig  in  1  trigger; each high cycle is one trigger event (normally one cycle wide from a oneshot).
- i_delay  in  CNT_W  cycles from trigger acceptance to pulse start; sampled on acceptance.
- i_width  in  CNT_W  pulse high time in cycles; sampled on acceptance; 0 is treated as 1.
- o_pulse  out  1  stretched output pulse, registered.
- o_busy  out  1  high in DELAY or ACTIVE, registered.
- o_dropped  out  1  one-cycle flag: a trigger arrived and was ignored.

Behaviour:
- Reset (i_reset=1 at a clock edge): state=IDLE, counters=0, o_pulse=0, o_busy=0, o_dropped=0. This applies mid-pulse too; the pulse ends at that edge with no completion.
- States:
  - IDLE: waiting for a trigger.
  - DELAY: counting i_delay.
  - ACTIVE: o_pulse high.
- Trigger acceptance: IDLE, i_enable=1, i_trig=1 at edge N.
  - Latch i_delay into the delay counter. Latch max(i_width,1) into the width counter.
  - If D=0, go to ACTIVE at N+1. Otherwise go to DELAY at N+1.
- DELAY: counter decrements each cycle. On the cycle it reaches 1, the next state is ACTIVE. Exactly D cycles are spent in DELAY.
- ACTIVE: o_pulse=1. Width counter decrements each cycle. After W cycles, return to IDLE and drop o_pulse.
- Timing: trigger sampled at edge N gives o_pulse high for edges N+1+D through N+D+W inclusive. Exactly W cycles high, no glitches.
- o_busy equals (state != IDLE), registered alongside the state.
- Triggers while busy:
  - i_trig=1 in DELAY or ACTIVE is ignored; o_dropped=1 for the following cycle.
  - Includes a trigger on the final ACTIVE cycle. Minimum accepted trigger spacing is D+W+1 cycles.
- i_enable=0 in any state: go to IDLE next edge, o_pulse=0, o_busy=0. Triggers are ignored without asserting o_dropped.
- i_delay and i_width changes after acceptance have no effect on the pulse in flight.
- Counter arithmetic is unsigned, CNT_W bits, decrement only. D=2^CNT_W-1 and W=2^CNT_W-1 are legal and must not wrap.

Optional Feature:
- Macro RETRIGGER_EN.
- Defined:
  - i_trig=1 in ACTIVE reloads the width counter with max(i_width,1) and does not assert o_dropped.
  - The pulse stays high continuously for W cycles after the last retrigger edge.
  - Triggers in DELAY are still dropped.
- Undefined: all triggers while busy are dropped as described above.

Decomposition:
- Shared package pulse_pkg:
  - state encoding constants IDLE=0, DELAY=1, ACTIVE=2;
  - default CNT_W;
  - a function returning max(w,1).
- One sub-module, pulse_down_counter: loadable CNT_W down-counter with load, decrement enable, and terminal (==1) flag. It is instantiated twice, once for delay and once for width.

Test Plan:
- Reset then trigger with D=0, W=1 at edge 10 -> o_pulse high only at edge 11; o_busy high edge 11 only; o_dropped never asserted.
- D=3, W=5, trigger at edge 20 -> o_pulse high edges 24-28; o_busy high edges 21-28.
- W=0, D=0 trigger -> exactly one cycle of o_pulse, same as W=1.
- D=0, W=4, trigger at edge 30 and again at 33 -> pulse edges 31-34 unchanged; o_dropped high edge 34. With RETRIGGER_EN: pulse edges 31-37, o_dropped never high.
- D=2, W=10, trigger at edge 40; i_reset=1 at edge 45 -> o_pulse and o_busy low from edge 45; a new trigger at edge 47 is accepted normally.
- D=0, W=8, trigger at edge 50; i_enable=0 at edge 52 -> o_pulse low from edge 53; trigger at edge 54 with enable low ignored, o_dropped stays 0.
